pleasure_level: RTL
===================

Name: pleasure_level

Overview:
- Downstream stage of the pleasure regulator. Integrates its pleasure_inc / pleasure_dec requests into a saturating pleasure level.
- Rate-limits steps with a hold-off window, so a stuck request cannot slew the level in consecutive ticks.
- Decays the level back toward neutral when no requests arrive for a set time.
- Publishes the level, a 2-bit mood class and a one-cycle change strobe for the display and personality logic.

Parameters:
- WIDTH, 4, level width; level range is 0 to 2^WIDTH-1.
- NEUTRAL, 8, reset value and decay target; must be at most 2^WIDTH-1.
- LOW_TH, 5, level at or below this gives mood 00; must be below NEUTRAL.
- HIGH_TH, 11, level at or above this gives mood 10; must be above NEUTRAL.
- HOLDOFF, 2, ticks blocked after a successful step; must be at least 0.
- DECAY_TICKS, 16, idle ticks before one decay step; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  time-base strobe; all level updates happen only on cycles where tick=1.
- pleasure_inc  in  1  increase request (level or pulse).
- pleasure_dec  in  1  decrease request (level or pulse).
- level  out  WIDTH  current pleasure level (registered).
- mood  out  2  00 unhappy, 01 neutral, 10 happy, 11 ecstatic.
- level_changed  out  1  one-cycle pulse when level changes.

Behaviour:
- Reset (rst=1 at a clk edge):
  - level=NEUTRAL, level_changed=0.
  - Pending flags, hold-off counter and decay counter all 0.
  - mood=01.
  - rst has priority over all other inputs, including mid-hold-off with requests pending.
- Request latching:
  - pend_inc is set on any cycle with pleasure_inc=1; pend_dec likewise with pleasure_dec=1.
  - The flags are sticky until consumed at a tick.
  - At a tick, the effective request is (pend | input) for that same cycle; a request arriving on the tick cycle counts.
- On a tick cycle, evaluate in this priority order:
  1. HOLD: hold-off counter is nonzero.
     - Decrement the hold-off counter.
     - Pending flags are kept; decay counter is frozen; level is unchanged.
  2. CANCEL: both effective inc and dec are set.
     - Clear both pending flags; clear the decay counter.
     - Level is unchanged; no hold-off; no pulse.
  3. STEP: exactly one of effective inc or dec is set.
     - Clear the pending flags and the decay counter.
     - If the level is not at its bound (2^WIDTH-1 for inc, 0 for dec): level ±1, hold-off counter = HOLDOFF, level_changed=1 next cycle.
     - If the level is already at its bound: level unchanged, no hold-off, no pulse.
  4. IDLE: no request.
     - If decay counter = DECAY_TICKS-1: decay counter = 0. If level ≠ NEUTRAL, move level one step toward NEUTRAL and pulse level_changed; no hold-off is loaded for decay.
     - Otherwise increment the decay counter.
- Non-tick cycles:
  - Only the pending flags may change; all counters and level hold.
  - level_changed is forced to 0.
- Timing:
  - level and level_changed update on the clk edge that samples tick=1 (1-cycle latency).
  - level_changed is high for exactly one cycle.
- mood is combinational from the level register, evaluated in this order:
  - level = 2^WIDTH-1 → 11;
  - else level ≥ HIGH_TH → 10;
  - else level ≤ LOW_TH → 00;
  - else 01.
- Counter widths: decay counter is $clog2(DECAY_TICKS) bits; hold-off counter is $clog2(HOLDOFF+1) bits (minimum 1). Neither counter wraps outside its defined range.
- With HOLDOFF=0, a held inc steps the level on every tick.

Test Plan:
- Reset: apply rst, then release → level=8, mood=01, level_changed=0; an inc pulse applied together with rst is discarded.
- Rate limit (tick every cycle): inc pulse at tick T → level=9 and a pulse at T+1. A second inc at T+1 is held pending through ticks T+1 and T+2 and applied at T+3 → level=10.
- Off-tick latching: tick every 4th cycle; one-cycle dec pulse between ticks → level 8→7 at the next tick; level_changed pulses once, mood stays 01.
- Saturation: preload level 15 via incs, keep pleasure_inc=1 → level stays 15, mood=11, no further level_changed pulses. The equivalent dec case at 0 → level stays 0, mood=00.
- Cancel and decay: inc+dec on the same tick at level 10 → level stays 10 and the decay counter clears. Then 16 idle ticks → 9; 16 more → 8; a further 32 idle ticks → stays 8 with no pulse.
- Reset mid-operation: rst asserted during hold-off with pend_dec set → level=8, no step applied on the next tick after release.

Source files
------------

// File: rtl/pleasure_level.sv
// pleasure_level
//   Integrates pleasure_inc / pleasure_dec requests from the pleasure regulator
//   into a saturating level. Steps are rate-limited by a hold-off window, and
//   the level decays one step toward NEUTRAL after DECAY_TICKS idle ticks.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   tick           time-base strobe; level/counters only update when tick=1
//   pleasure_inc   increase request (level or pulse), latched until a tick
//   pleasure_dec   decrease request (level or pulse), latched until a tick
//   level          registered pleasure level, 0 .. 2^WIDTH-1
//   mood           00 unhappy, 01 neutral, 10 happy, 11 ecstatic
//   level_changed  one-cycle pulse after any change of level
module pleasure_level #(
    parameter int WIDTH       = 4,
    parameter int NEUTRAL     = 8,
    parameter int LOW_TH      = 5,
    parameter int HIGH_TH     = 11,
    parameter int HOLDOFF     = 2,
    parameter int DECAY_TICKS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             pleasure_inc,
    input  logic             pleasure_dec,
    output logic [WIDTH-1:0] level,
    output logic [1:0]       mood,
    output logic             level_changed
);

    localparam int DECAY_W = $clog2(DECAY_TICKS);
    // A zero hold-off still needs a 1-bit counter that simply never loads.
    localparam int HOLD_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [WIDTH-1:0]   LVL_MAX     = '1;
    localparam logic [WIDTH-1:0]   LVL_NEUTRAL = WIDTH'(NEUTRAL);
    localparam logic [WIDTH-1:0]   LVL_LOW     = WIDTH'(LOW_TH);
    localparam logic [WIDTH-1:0]   LVL_HIGH    = WIDTH'(HIGH_TH);
    localparam logic [DECAY_W-1:0] DECAY_LAST  = DECAY_W'(DECAY_TICKS - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD   = HOLD_W'(HOLDOFF);

    logic               pend_inc, pend_dec;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [DECAY_W-1:0] decay_cnt;

    logic               pend_inc_nxt, pend_dec_nxt;
    logic [HOLD_W-1:0]  hold_nxt;
    logic [DECAY_W-1:0] decay_nxt;
    logic [WIDTH-1:0]   level_nxt;
    logic               changed_nxt;
    logic               eff_inc, eff_dec;
    logic [WIDTH-1:0]   stepped;

    // One saturating step up or down; returns the input unchanged at a bound.
    function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] cur,
                                                  input logic             up);
        if (up)
            return (cur == LVL_MAX) ? cur : cur + 1'b1;
        else
            return (cur == '0) ? cur : cur - 1'b1;
    endfunction

    always_comb begin
        // A request arriving on the tick cycle itself is honoured.
        eff_inc      = pend_inc | pleasure_inc;
        eff_dec      = pend_dec | pleasure_dec;
        pend_inc_nxt = eff_inc;
        pend_dec_nxt = eff_dec;
        hold_nxt     = hold_cnt;
        decay_nxt    = decay_cnt;
        level_nxt    = level;
        changed_nxt  = 1'b0;
        stepped      = level;

        if (tick) begin
            if (hold_cnt != '0) begin
                // Pending requests wait out the window; decay is frozen.
                hold_nxt = hold_cnt - 1'b1;
            end else if (eff_inc && eff_dec) begin
                pend_inc_nxt = 1'b0;
                pend_dec_nxt = 1'b0;
                decay_nxt    = '0;
            end else if (eff_inc || eff_dec) begin
                pend_inc_nxt = 1'b0;
                pend_dec_nxt = 1'b0;
                decay_nxt    = '0;
                stepped      = sat_step(level, eff_inc);
                // Hitting a bound is not a step: no hold-off, no pulse.
                if (stepped != level) begin
                    level_nxt   = stepped;
                    hold_nxt    = HOLD_LOAD;
                    changed_nxt = 1'b1;
                end
            end else if (decay_cnt == DECAY_LAST) begin
                decay_nxt = '0;
                if (level != LVL_NEUTRAL) begin
                    level_nxt   = sat_step(level, level < LVL_NEUTRAL);
                    changed_nxt = 1'b1;
                end
            end else begin
                decay_nxt = decay_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_inc      <= 1'b0;
            pend_dec      <= 1'b0;
            hold_cnt      <= '0;
            decay_cnt     <= '0;
            level         <= LVL_NEUTRAL;
            level_changed <= 1'b0;
        end else begin
            pend_inc      <= pend_inc_nxt;
            pend_dec      <= pend_dec_nxt;
            hold_cnt      <= hold_nxt;
            decay_cnt     <= decay_nxt;
            level         <= level_nxt;
            level_changed <= changed_nxt;
        end
    end

    always_comb begin
        if (level == LVL_MAX)
            mood = 2'b11;
        else if (level >= LVL_HIGH)
            mood = 2'b10;
        else if (level <= LVL_LOW)
            mood = 2'b00;
        else
            mood = 2'b01;
    end

endmodule
